// File: rtl/cpu0_mem_responder_if.sv
// Request/response bus between the CPU0 core (master) and its memory responder (slave).
interface cpu0_mem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        err;

   modport master (output req, we, addr, wdata, input rdata, ack, err);
   modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/cpu0_mem_responder.sv
// Big-endian byte-addressed word memory for CPU0 with wait states and range check.
// Optional access trace: define CPU0_MEM_TRACE_EN.
module cpu0_mem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input logic                  clock,
   input logic                  reset_n,
   cpu0_mem_responder_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0]  mem_q [DEPTH];

   logic          enter_resp;
   logic [31:0]   acc_addr, acc_wdata;
   logic          acc_we, legal;
   logic [AW-1:0] idx0, idx1, idx2, idx3;
   logic [31:0]   rd_word;

   // With zero wait states the access happens on the accepting edge, so use the live inputs.
   assign acc_addr  = (state_q == S_IDLE) ? bus.addr  : addr_q;
   assign acc_wdata = (state_q == S_IDLE) ? bus.wdata : wdata_q;
   assign acc_we    = (state_q == S_IDLE) ? bus.we    : we_q;
   assign legal     = acc_addr <= 32'(DEPTH - 4);

   assign idx0    = acc_addr[AW-1:0];
   assign idx1    = idx0 + AW'(1);
   assign idx2    = idx0 + AW'(2);
   assign idx3    = idx0 + AW'(3);
   assign rd_word = {mem_q[idx0], mem_q[idx1], mem_q[idx2], mem_q[idx3]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               we_d    = bus.we;
               if (WAIT_CYCLES == 0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      ack_d   = enter_resp;
      err_d   = enter_resp && !legal;
      rdata_d = rdata_q;
      if (enter_resp && !acc_we) rdata_d = legal ? rd_word : 32'h0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Stores commit only on RESP entry, so a reset during WAIT drops them.
   always_ff @(posedge clock) begin
      if (enter_resp && acc_we && legal) begin
         mem_q[idx0] <= acc_wdata[31:24];
         mem_q[idx1] <= acc_wdata[23:16];
         mem_q[idx2] <= acc_wdata[15:8];
         mem_q[idx3] <= acc_wdata[7:0];
      end
   end

`ifdef CPU0_MEM_TRACE_EN
   always_ff @(posedge clock) begin
      if (enter_resp)
         $display("%0d %s %08h %08h%s", $stime, acc_we ? "ST" : "LD", acc_addr,
                  acc_we ? acc_wdata : (legal ? rd_word : 32'h0), legal ? "" : " ERR");
   end
`else
`endif

   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_cpu0_mem_responder.sv
// Scoreboard bench: two responders (0 and 2 wait states) against a byte-array reference model.
module tb_cpu0_mem_responder;
   localparam int DEPTH = 1024;
   localparam int NDUT  = 2;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst_n   [NDUT];
   logic        req_v   [NDUT];
   logic        we_v    [NDUT];
   logic [31:0] addr_v  [NDUT];
   logic [31:0] wdata_v [NDUT];
   logic        ack_v   [NDUT];
   logic        err_v   [NDUT];
   logic [31:0] rdata_v [NDUT];
   logic        prev_ack[NDUT];

   logic [7:0]  mm [NDUT][DEPTH];
   logic [31:0] last_rd [NDUT];
   exp_t        q0[$];
   exp_t        q1[$];
   int          total = 0;
   int          bad   = 0;

   always #5 clock = ~clock;

   cpu0_mem_responder_if bus0();
   cpu0_mem_responder_if bus1();

   cpu0_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u0 (
      .clock(clock), .reset_n(rst_n[0]), .bus(bus0.slave));
   cpu0_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u1 (
      .clock(clock), .reset_n(rst_n[1]), .bus(bus1.slave));

   assign bus0.req = req_v[0];  assign bus0.we = we_v[0];
   assign bus0.addr = addr_v[0]; assign bus0.wdata = wdata_v[0];
   assign bus1.req = req_v[1];  assign bus1.we = we_v[1];
   assign bus1.addr = addr_v[1]; assign bus1.wdata = wdata_v[1];
   assign ack_v[0] = bus0.ack; assign err_v[0] = bus0.err; assign rdata_v[0] = bus0.rdata;
   assign ack_v[1] = bus1.ack; assign err_v[1] = bus1.err; assign rdata_v[1] = bus1.rdata;

   function automatic int wc(input int s);
      return (s == 0) ? 0 : 2;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   // Reference: memory is a plain byte array; a load reads four consecutive bytes MSB first.
   function automatic exp_t model(input int s, input logic w, input logic [31:0] a,
                                  input logic [31:0] d);
      exp_t e;
      int   ia;
      bit   ok;
      ok    = (a <= 32'(DEPTH - 4));
      ia    = ok ? int'(a) : 0;
      e.err = !ok;
      if (w) begin
         if (ok) for (int k = 0; k < 4; k++) mm[s][ia+k] = d[31-8*k -: 8];
      end else begin
         last_rd[s] = ok ? {mm[s][ia], mm[s][ia+1], mm[s][ia+2], mm[s][ia+3]} : 32'h0;
      end
      e.rdata = last_rd[s];
      return e;
   endfunction

   function automatic void push(input int s, input exp_t e);
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   // Monitor: pops one expectation per ack and checks pulse shape.
   always @(negedge clock) begin
      for (int s = 0; s < NDUT; s++) begin
         if (ack_v[s] === 1'b1) begin
            exp_t e;
            bit   have;
            have = 1'b0;
            if (s == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (s == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            chk($sformatf("ack_pulse dut%0d", s), 32'(prev_ack[s]), 32'h0);
            if (!have) begin
               total++;
               bad++;
               $display("FAIL unexpected_ack dut%0d: got ack=1 want no ack", s);
            end else begin
               chk($sformatf("err dut%0d", s), 32'(err_v[s]), 32'(e.err));
               chk($sformatf("rdata dut%0d", s), rdata_v[s], e.rdata);
            end
         end else begin
            chk($sformatf("err_noack dut%0d", s), 32'(err_v[s]), 32'h0);
         end
         prev_ack[s] = ack_v[s];
      end
   end

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic issue(input int s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble);
      int n;
      bit got;
      push(s, model(s, w, a, d));
      req_v[s] = 1'b1; we_v[s] = w; addr_v[s] = a; wdata_v[s] = d;
      n = 0; got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clock);
         n++;
         if (ack_v[s] === 1'b1) got = 1'b1;
         else if (scramble) begin addr_v[s] = $urandom; wdata_v[s] = $urandom; end
      end
      chk($sformatf("latency dut%0d", s), 32'(n), 32'(wc(s) + 1));
      req_v[s] = 1'b0;
      @(negedge clock);
   endtask

   task automatic back_to_back(input int s, input logic [31:0] a);
      int first, second, n;
      push(s, model(s, 1'b0, a, 32'h0));
      push(s, model(s, 1'b0, a, 32'h0));
      req_v[s] = 1'b1; we_v[s] = 1'b0; addr_v[s] = a;
      first = -1; second = -1; n = 0;
      while (second < 0 && n < 30) begin
         @(negedge clock);
         n++;
         if (ack_v[s] === 1'b1) begin
            if (first < 0) first = n;
            else begin second = n; req_v[s] = 1'b0; end
         end
      end
      req_v[s] = 1'b0;
      chk($sformatf("b2b_first dut%0d", s), 32'(first), 32'(wc(s) + 1));
      chk($sformatf("b2b_second dut%0d", s), 32'(second), 32'(2 * wc(s) + 3));
      @(negedge clock);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int s = 0; s < NDUT; s++) begin
         rst_n[s] = 1'b0; req_v[s] = 1'b0; we_v[s] = 1'b0;
         addr_v[s] = '0; wdata_v[s] = '0; last_rd[s] = '0; prev_ack[s] = 1'b0;
         for (int i = 0; i < DEPTH; i++) mm[s][i] = 8'h0;
      end
      repeat (3) @(negedge clock);
      for (int s = 0; s < NDUT; s++) begin
         chk($sformatf("rst_ack dut%0d", s), 32'(ack_v[s]), 32'h0);
         chk($sformatf("rst_rdata dut%0d", s), rdata_v[s], 32'h0);
      end
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      @(negedge clock);

      for (int s = 0; s < NDUT; s++) begin
         for (int a = 0; a < DEPTH; a += 4) issue(s, 1'b1, 32'(a), 32'h0, 1'b0);
         issue(s, 1'b1, 32'h0C, 32'h13221000, 1'b0);
         issue(s, 1'b0, 32'h0C, 32'h0, 1'b0);
         issue(s, 1'b1, 32'h20, 32'h11223344, 1'b0);
         issue(s, 1'b1, 32'h22, 32'hAABBCCDD, 1'b0);
         issue(s, 1'b0, 32'h20, 32'h0, 1'b0);
         issue(s, 1'b0, 32'h24, 32'h0, 1'b0);
         issue(s, 1'b1, 32'h3FC, 32'h12345678, 1'b0);
         issue(s, 1'b1, 32'h3FD, 32'h9ABCDEF0, 1'b0);
         issue(s, 1'b0, 32'h3FC, 32'h0, 1'b0);
         issue(s, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b0);
         back_to_back(s, 32'h0C);
      end

      // Mid-transaction input changes must not affect the latched access.
      issue(1, 1'b1, 32'h40, 32'hCAFEF00D, 1'b1);
      issue(1, 1'b0, 32'h40, 32'h0, 1'b1);

      // Reset during WAIT drops the pending store.
      issue(1, 1'b1, 32'h10, 32'h13332000, 1'b0);
      issue(1, 1'b0, 32'h10, 32'h0, 1'b0);
      req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h10; wdata_v[1] = 32'hDEADBEEF;
      @(negedge clock);
      rst_n[1] = 1'b0;
      req_v[1] = 1'b0;
      #1;
      chk("midrst_ack", 32'(ack_v[1]), 32'h0);
      chk("midrst_err", 32'(err_v[1]), 32'h0);
      chk("midrst_rdata", rdata_v[1], 32'h0);
      last_rd[1] = 32'h0;
      repeat (3) @(negedge clock);
      rst_n[1] = 1'b1;
      @(negedge clock);
      issue(1, 1'b0, 32'h10, 32'h0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         int          s, r;
         logic        w;
         logic [31:0] a;
         s = i % NDUT;
         w = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         if (r < 6)       a = 32'($urandom_range(0, 64));
         else if (r < 8)  a = 32'h3F8 + 32'($urandom_range(0, 7));
         else if (r == 8) a = $urandom;
         else             a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
         issue(s, w, a, $urandom, 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clock);
      chk("sb_empty dut0", 32'(q0.size()), 32'h0);
      chk("sb_empty dut1", 32'(q1.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
